// File: rtl/simon_round_ctrl.sv
// -----------------------------------------------------------------------------
// simon_round_ctrl
// Iterative SIMON 128/128 encryption engine. One Feistel round per clock with
// the key schedule expanded on the fly alongside the rounds. The plaintext and
// key are taken over a valid/ready handshake in IDLE and the ciphertext is held
// on ct_x/ct_y, with out_valid high, until the consumer accepts it.
//
// Parameters
//   WORD_SIZE  Feistel half-word width n (only 64 is supported)
//   ROUNDS     round count T (68 for SIMON 128/128)
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset, aborts any operation
//   in_valid   plaintext/key offered
//   in_ready   engine can accept (IDLE only)
//   pt_x/pt_y  plaintext upper/lower words, sampled on the accept edge
//   key_hi     key word k1
//   key_lo     key word k0, used in round 0
//   busy       high while rounds are executing
//   out_valid  ciphertext valid and held stable
//   out_ready  consumer accepts ciphertext (honoured in DONE only)
//   ct_x/ct_y  ciphertext upper/lower words
// -----------------------------------------------------------------------------
module simon_round_ctrl #(
    parameter int WORD_SIZE = 64,
    parameter int ROUNDS    = 68
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WORD_SIZE-1:0] pt_x,
    input  logic [WORD_SIZE-1:0] pt_y,
    input  logic [WORD_SIZE-1:0] key_hi,
    input  logic [WORD_SIZE-1:0] key_lo,
    output logic                 busy,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WORD_SIZE-1:0] ct_x,
    output logic [WORD_SIZE-1:0] ct_y
);

    // z2 constant sequence, bit 0 of the sequence is the MSB of this literal.
    localparam logic [61:0] Z2 =
        62'b10101111011100000011010010011000101000010001111110010110110011;
    localparam logic [6:0] LAST_RND = 7'(ROUNDS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic                   w_load;
    logic                   w_step;

    logic [WORD_SIZE-1:0]   r_x;
    logic [WORD_SIZE-1:0]   r_y;
    logic [WORD_SIZE-1:0]   r_ka;
    logic [WORD_SIZE-1:0]   r_kb;
    logic [6:0]             r_rnd;
    logic [5:0]             r_zidx;

    logic [WORD_SIZE-1:0]   w_f;
    logic [WORD_SIZE-1:0]   w_t0;
    logic [WORD_SIZE-1:0]   w_t;
    logic                   w_zbit;
    logic [WORD_SIZE-1:0]   w_knew;

    function automatic logic [WORD_SIZE-1:0] rotl(input logic [WORD_SIZE-1:0] v,
                                                  input int unsigned j);
        return (v << j) | (v >> (WORD_SIZE - j));
    endfunction

    function automatic logic [WORD_SIZE-1:0] rotr(input logic [WORD_SIZE-1:0] v,
                                                  input int unsigned j);
        return (v >> j) | (v << (WORD_SIZE - j));
    endfunction

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        busy        = 1'b0;
        out_valid   = 1'b0;
        w_load      = 1'b0;
        w_step      = 1'b0;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_load      = 1'b1;
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                busy   = 1'b1;
                w_step = 1'b1;
                // Final round's update lands on the same edge as the exit.
                if (r_rnd == LAST_RND) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ---------------------------------------------------------- datapath
    always_comb begin
        w_f    = (rotl(r_x, 1) & rotl(r_x, 8)) ^ rotl(r_x, 2);
        w_t0   = rotr(r_kb, 3);
        w_t    = w_t0 ^ rotr(w_t0, 1);
        w_zbit = Z2[6'd61 - r_zidx];
        w_knew = ~r_ka ^ w_t ^ {{(WORD_SIZE-1){1'b0}}, w_zbit} ^ WORD_SIZE'(3);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_x    <= '0;
            r_y    <= '0;
            r_ka   <= '0;
            r_kb   <= '0;
            r_rnd  <= '0;
            r_zidx <= '0;
        end else if (w_load) begin
            r_x    <= pt_x;
            r_y    <= pt_y;
            r_ka   <= key_lo;
            r_kb   <= key_hi;
            r_rnd  <= '0;
            r_zidx <= '0;
        end else if (w_step) begin
            r_x    <= r_y ^ w_f ^ r_ka;
            r_y    <= r_x;
            r_ka   <= r_kb;
            r_kb   <= w_knew;
            r_rnd  <= r_rnd + 7'd1;
            r_zidx <= (r_zidx == 6'd61) ? 6'd0 : r_zidx + 6'd1;
        end
    end

    assign ct_x = r_x;
    assign ct_y = r_y;

endmodule

// File: tb/tb_simon_round_ctrl.sv
// -----------------------------------------------------------------------------
// tb_simon_round_ctrl
// Scoreboard bench for simon_round_ctrl. The driver pushes the expected
// ciphertext when it issues a block; a negedge monitor pops and compares on
// every output handshake and checks accept-to-valid latency.
// -----------------------------------------------------------------------------
module tb_simon_round_ctrl;

    localparam logic [63:0] KAT_K1 = 64'h0f0e0d0c0b0a0908;
    localparam logic [63:0] KAT_K0 = 64'h0706050403020100;
    localparam logic [63:0] KAT_PX = 64'h6373656420737265;
    localparam logic [63:0] KAT_PY = 64'h6c6c657661727420;
    localparam logic [127:0] KAT_CT = {64'h49681b1e1e54fe3f, 64'h65aa832af84e0bbc};

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] pt_x, pt_y, key_hi, key_lo;
    logic        busy;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] ct_x, ct_y;

    int checks = 0;
    int errors = 0;

    logic [127:0] exp_q[$];
    int unsigned  acc_q[$];
    int unsigned  edges = 0;
    int unsigned  n_acc = 0;
    int unsigned  prev_rise = 0;
    int unsigned  last_rise = 0;
    logic         prev_ov = 1'b0;

    simon_round_ctrl #(.WORD_SIZE(64), .ROUNDS(68)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .pt_x(pt_x), .pt_y(pt_y), .key_hi(key_hi), .key_lo(key_lo),
        .busy(busy), .out_valid(out_valid), .out_ready(out_ready),
        .ct_x(ct_x), .ct_y(ct_y)
    );

    always #5 clk = ~clk;
    always @(posedge clk) edges <= edges + 1;

    // --------------------------------------------------------- reference
    function automatic logic [63:0] rol(input logic [63:0] v, input int j);
        logic [127:0] d;
        d = {v, v};
        return d[127-j -: 64];
    endfunction

    function automatic logic [63:0] ror(input logic [63:0] v, input int j);
        logic [127:0] d;
        d = {v, v};
        return d[j+63 -: 64];
    endfunction

    function automatic logic [127:0] simon_ref(input logic [63:0] k1, input logic [63:0] k0,
                                               input logic [63:0] px, input logic [63:0] py);
        logic [63:0] k[0:67];
        logic [61:0] z;
        logic [63:0] t, x, y, tmp;
        z = 62'b10101111011100000011010010011000101000010001111110010110110011;
        k[0] = k0;
        k[1] = k1;
        for (int i = 0; i < 66; i++) begin
            t = ror(k[i+1], 3);
            t = t ^ ror(t, 1);
            k[i+2] = ~k[i] ^ t ^ {63'd0, z[61 - (i % 62)]} ^ 64'd3;
        end
        x = px;
        y = py;
        for (int i = 0; i < 68; i++) begin
            tmp = x;
            x = y ^ (rol(x, 1) & rol(x, 8)) ^ rol(x, 2) ^ k[i];
            y = tmp;
        end
        return {x, y};
    endfunction

    // ----------------------------------------------------------- monitor
    always @(negedge clk) begin
        int unsigned  a;
        logic [127:0] e;
        if (!rst_n) begin
            prev_ov = 1'b0;
        end else begin
            if (out_valid && !prev_ov) begin
                checks++;
                if (acc_q.size() == 0) begin
                    errors++;
                    $display("FAIL latency: out_valid rose with no recorded accept");
                end else begin
                    a = acc_q.pop_front();
                    if (edges - a != 68) begin
                        errors++;
                        $display("FAIL latency: got %0d cycles, want 68", edges - a);
                    end
                end
                prev_rise = last_rise;
                last_rise = edges;
            end
            if (out_valid && out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL result: unexpected output %h", {ct_x, ct_y});
                end else begin
                    e = exp_q.pop_front();
                    if ({ct_x, ct_y} !== e) begin
                        errors++;
                        $display("FAIL result: got %h want %h", {ct_x, ct_y}, e);
                    end
                end
            end
            if (in_valid && in_ready) begin
                acc_q.push_back(edges + 1);
                n_acc++;
            end
            prev_ov = out_valid;
        end
    end

    // ------------------------------------------------------------ driver
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    task automatic set_bus(input logic [63:0] k1, input logic [63:0] k0,
                           input logic [63:0] px, input logic [63:0] py);
        key_hi = k1;
        key_lo = k0;
        pt_x   = px;
        pt_y   = py;
    endtask

    task automatic send(input logic [63:0] k1, input logic [63:0] k0,
                        input logic [63:0] px, input logic [63:0] py,
                        input logic [127:0] e);
        bit ok;
        ok = 1'b0;
        exp_q.push_back(e);
        set_bus(k1, k0, px, py);
        in_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            #1;
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: in_ready got 0 want 1");
        end
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        for (int i = 0; i < budget && exp_q.size() != 0; i++) begin
            @(negedge clk);
            #1;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: pending %0d want 0", exp_q.size());
            exp_q.delete();
            acc_q.delete();
        end
        tick();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned  base;
        bit           seen;
        logic [63:0]  rk1, rk0, rpx, rpy;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        set_bus('0, '0, '0, '0);
        tick();
        tick();
        chk("reset_in_ready", 128'(in_ready), 128'd1);
        chk("reset_busy", 128'(busy), 128'd0);
        chk("reset_out_valid", 128'(out_valid), 128'd0);
        chk("reset_ct", {ct_x, ct_y}, 128'd0);
        rst_n = 1'b1;
        tick();

        // Known answer
        out_ready = 1'b1;
        send(KAT_K1, KAT_K0, KAT_PX, KAT_PY, KAT_CT);
        chk("run_busy", 128'(busy), 128'd1);
        chk("run_in_ready", 128'(in_ready), 128'd0);
        wait_drain(150);

        // Backpressure with ignored in_valid
        out_ready = 1'b0;
        send(KAT_K1, KAT_K0, KAT_PX, KAT_PY, KAT_CT);
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (out_valid) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        chk("bp_reached_done", 128'(seen), 128'd1);
        base = n_acc;
        for (int i = 0; i < 20; i++) begin
            in_valid = 1'b1;
            set_bus(64'(i) * 64'h1111, ~64'(i), 64'hdead_beef_0000_0000 | 64'(i), '1);
            chk("bp_out_valid", 128'(out_valid), 128'd1);
            chk("bp_in_ready", 128'(in_ready), 128'd0);
            chk("bp_ct_stable", {ct_x, ct_y}, KAT_CT);
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("bp_in_ready_after", 128'(in_ready), 128'd1);
        chk("bp_out_valid_after", 128'(out_valid), 128'd0);
        chk("bp_no_extra_accept", 128'(n_acc - base), 128'd0);
        chk("bp_drained", 128'(exp_q.size()), 128'd0);

        // Back-to-back with in_valid and out_ready tied high
        base = n_acc;
        exp_q.push_back(KAT_CT);
        exp_q.push_back(KAT_CT);
        set_bus(KAT_K1, KAT_K0, KAT_PX, KAT_PY);
        in_valid = 1'b1;
        for (int i = 0; i < 300 && n_acc < base + 2; i++) begin
            @(negedge clk);
            #1;
        end
        tick();
        in_valid = 1'b0;
        chk("b2b_accepts", 128'(n_acc - base), 128'd2);
        wait_drain(200);
        chk("b2b_spacing", 128'(last_rise - prev_rise), 128'd70);

        // Mid-run reset at round 30
        send(KAT_K1, KAT_K0, KAT_PX, KAT_PY, KAT_CT);
        repeat (30) tick();
        rst_n = 1'b0;
        #1;
        chk("mrst_in_ready", 128'(in_ready), 128'd1);
        chk("mrst_busy", 128'(busy), 128'd0);
        chk("mrst_out_valid", 128'(out_valid), 128'd0);
        chk("mrst_ct", {ct_x, ct_y}, 128'd0);
        exp_q.delete();
        acc_q.delete();
        tick();
        rst_n = 1'b1;
        tick();
        send(KAT_K1, KAT_K0, KAT_PX, KAT_PY, KAT_CT);
        wait_drain(150);

        // Input isolation: buses and in_valid churn during RUN
        out_ready = 1'b0;
        send(KAT_K1, KAT_K0, KAT_PX, KAT_PY, KAT_CT);
        for (int i = 0; i < 100 && !out_valid; i++) begin
            set_bus({$urandom, $urandom}, {$urandom, $urandom},
                    {$urandom, $urandom}, {$urandom, $urandom});
            in_valid = 1'($urandom_range(0, 1));
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        wait_drain(150);

        // Random compare against the reference model
        for (int n = 0; n < 200; n++) begin
            rpx = {$urandom, $urandom};
            rpy = {$urandom, $urandom};
            if (n == 0) begin
                rk1 = '0;
                rk0 = '0;
            end else if (n == 1) begin
                rk1 = '1;
                rk0 = '1;
            end else begin
                rk1 = {$urandom, $urandom};
                rk0 = {$urandom, $urandom};
            end
            send(rk1, rk0, rpx, rpy, simon_ref(rk1, rk0, rpx, rpy));
            wait_drain(150);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/simon_round_ctrl.md
# simon_round_ctrl

Iterative SIMON 128/128 encryption engine: accepts a 128-bit plaintext and 128-bit key, runs the 68-round Feistel loop one round per clock with on-the-fly key expansion, and returns the ciphertext over a valid/ready handshake. It sits between the host-side data interface and the shared rotate datapath. It sequences the three left-rotate units (by 1, 8 and 2) and the key-schedule right-rotates (by 3 and 1).

## Interface
- WORD_SIZE, 64, Feistel half-word width n; only 64 is supported.
- ROUNDS, 68, round count T for SIMON 128/128.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  plaintext/key offered
- in_ready  out  1  engine can accept; high only in IDLE
- pt_x  in  64  plaintext upper word x
- pt_y  in  64  plaintext lower word y
- key_hi  in  64  key word k1
- key_lo  in  64  key word k0, used in round 0
- busy  out  1  high in RUN
- out_valid  in/out: out  1  ciphertext held valid
- out_ready  in  1  consumer accepts ciphertext
- ct_x  out  64  ciphertext upper word
- ct_y  out  64  ciphertext lower word

## Operation
- FSM states:
  - IDLE: in_ready=1. in_valid=1 loads x<=pt_x, y<=pt_y, ka<=key_lo, kb<=key_hi, rnd<=0, then goes to RUN.
  - RUN: one round per cycle.
  - DONE: out_valid=1. out_ready=1 returns to IDLE.
- Rotation: S^j is a left rotate by j over 64 bits. S^-j is a right rotate by j.
- Round i, with k = ka:
  - x <= y ^ ((S^1 x) & (S^8 x)) ^ (S^2 x) ^ k
  - y <= x
- Key schedule in the same cycle:
  - t = S^-3 kb; t = t ^ S^-1 t
  - knew = ~ka ^ t ^ z ^ 64'h3, where z is a 64-bit value equal to z2[i mod 62] zero-extended
  - ka <= kb; kb <= knew
- z2 is the 62-bit string 10101111011100000011010010011000101000010001111110010110110011, indexed from the left starting at 0.
  - Implement it as a 6-bit index that wraps 61→0 or as a rotating 62-bit register. Either must give z2[i mod 62].
- rnd is 7 bits. RUN exits to DONE on the cycle rnd==ROUNDS-1, with that round's update applied.
- ct_x/ct_y are wired directly from x/y. They are stable while out_valid=1 and don't-care otherwise.
- in_valid is ignored outside IDLE, and input buses are sampled only on the accept edge.
- out_ready is ignored outside DONE.
- Reset: async assertion at any time, including mid-RUN or in DONE, aborts the operation.
  - Reset values: state=IDLE, in_ready=1, busy=0, out_valid=0, x=y=ka=kb=0, rnd=0, z index=0.
  - No partial result is ever presented.

## Timing
- The accept edge E0 occurs when in_valid && in_ready.
- Rounds 0..67 execute on edges E1..E68. busy is high from after E0 through E68.
- out_valid rises after E68, giving 68 cycles from accept to result.
- out_valid holds until a rising edge with out_ready=1, at E_d.
- in_ready rises after E_d. The next accept can occur at E_d+1.
- Minimum period is 70 cycles per block: accept, 68 rounds, one DONE cycle with out_ready tied high.
- out_ready held high in advance is legal. It takes effect on the first DONE cycle.
- in_valid and out_ready both high while in DONE: out_ready is honoured and in_valid is ignored. The new block is accepted one cycle later, in IDLE.

## Test plan
- Known answer:
  - Inputs: key_hi=0f0e0d0c0b0a0908, key_lo=0706050403020100, pt_x=6373656420737265, pt_y=6c6c657661727420.
  - Required: out_valid exactly 68 cycles after accept, with ct_x=49681b1e1e54fe3f, ct_y=65aa832af84e0bbc.
- Backpressure: hold out_ready=0 for 20 cycles after out_valid. ct_x/ct_y and out_valid must stay stable, in_ready=0, and new in_valid must be ignored. Then release out_ready: one-cycle handoff, and in_ready=1 on the following cycle.
- Back-to-back: run the same vector twice with in_valid and out_ready tied high. Expect two identical correct results spaced 70 cycles apart.
- Mid-run reset: assert rst_n=0 at round 30. All outputs must immediately take their reset values. Then rerun the known answer and expect the correct ciphertext, proving no stale key or z-index state.
- Input isolation: change pt_x, pt_y and keys every cycle during RUN. The result must still match the known answer for the values sampled at E0.
- Random compare: 200 random key/plaintext pairs checked against a bench reference model, including all-zero and all-ones keys. This exercises z wrap at round 62.
